// File: rtl/chess_pkg.sv
// Shared constants, direction indices and scheduler state encoding for the
// move-generation scan logic.
package chess_pkg;

    localparam int MOVE_W       = 24;
    localparam int NUM_DIRS     = 16;
    localparam int DIR_W        = 4;
    localparam int MOVE_COUNT_W = 11;

    localparam logic [MOVE_W-1:0]       EMPTY_MOVE_OUT = 24'h000000;
    localparam logic [MOVE_COUNT_W-1:0] MOVE_COUNT_MAX = 11'd1024;

    // Order in which direction words appear inside the 384-bit move bundle.
    typedef enum logic [DIR_W-1:0] {
        DIR_U   = 4'd0,
        DIR_D   = 4'd1,
        DIR_L   = 4'd2,
        DIR_R   = 4'd3,
        DIR_UL  = 4'd4,
        DIR_UR  = 4'd5,
        DIR_DL  = 4'd6,
        DIR_DR  = 4'd7,
        DIR_UUL = 4'd8,
        DIR_UUR = 4'd9,
        DIR_LLU = 4'd10,
        DIR_RRU = 4'd11,
        DIR_DDL = 4'd12,
        DIR_DDR = 4'd13,
        DIR_LLD = 4'd14,
        DIR_RRD = 4'd15
    } dir_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SCAN   = 2'd2,
        ST_DONE   = 2'd3
    } sched_state_e;

    function automatic logic [MOVE_COUNT_W-1:0] sat_inc(input logic [MOVE_COUNT_W-1:0] v);
        return (v == MOVE_COUNT_MAX) ? v : v + 11'd1;
    endfunction

endpackage

// File: rtl/move_dir_mux.sv
// Picks one direction's move word out of the selected square's bundle and
// flags whether that direction holds no move.
module move_dir_mux
    import chess_pkg::*;
(
    input  logic [NUM_DIRS*MOVE_W-1:0] moves_i,
    input  logic [DIR_W-1:0]           dir_idx_i,
    output logic [MOVE_W-1:0]          word_o,
    output logic                       is_empty_o
);

    always_comb begin
        word_o     = moves_i[32'(dir_idx_i)*MOVE_W +: MOVE_W];
        is_empty_o = (word_o == EMPTY_MOVE_OUT);
    end

endmodule

// File: rtl/move_scan_scheduler.sv
// Walks every square of the move-generation array, waits for its chains to
// settle, then streams its non-empty direction words over valid/ready.
module move_scan_scheduler
    import chess_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int NUM_SQUARES   = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       abort,
    input  logic [NUM_DIRS*MOVE_W-1:0] moves_in,
    output logic [5:0]                 sq_sel,
    output logic                       busy,
    output logic                       move_valid,
    output logic [MOVE_W-1:0]          move_data,
    input  logic                       move_ready,
    output logic [MOVE_COUNT_W-1:0]    move_count,
    output logic                       done
);

    localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [5:0]       LAST_SQ     = 6'(NUM_SQUARES - 1);
    localparam logic [DIR_W-1:0] LAST_DIR    = 4'(NUM_DIRS - 1);

    sched_state_e              state_q, state_d;
    logic [5:0]                sq_sel_q, sq_sel_d;
    logic [DIR_W-1:0]          dir_idx_q, dir_idx_d;
    logic [3:0]                settle_cnt_q, settle_cnt_d;
    logic                      move_valid_q, move_valid_d;
    logic [MOVE_W-1:0]         move_data_q, move_data_d;
    logic [MOVE_COUNT_W-1:0]   move_count_q, move_count_d;
    logic                      done_q, done_d;
    logic                      busy_q, busy_d;
    logic                      drain_q, drain_d;

    logic [MOVE_W-1:0]         dir_word;
    logic                      dir_empty;

    move_dir_mux u_dir_mux (
        .moves_i    (moves_in),
        .dir_idx_i  (dir_idx_q),
        .word_o     (dir_word),
        .is_empty_o (dir_empty)
    );

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path
        // through the case below leaves one unassigned and infers a latch.
        state_d      = state_q;
        sq_sel_d     = sq_sel_q;
        dir_idx_d    = dir_idx_q;
        settle_cnt_d = settle_cnt_q;
        move_valid_d = move_valid_q;
        move_data_d  = move_data_q;
        move_count_d = move_count_q;
        drain_d      = drain_q;

        // The handshake runs independently of the scan, including through SETTLE.
        if (move_valid_q && move_ready) begin
            move_valid_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d      = ST_SETTLE;
                    sq_sel_d     = '0;
                    dir_idx_d    = '0;
                    settle_cnt_d = '0;
                    move_count_d = '0;
                    drain_d      = 1'b0;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt_q == SETTLE_LAST) begin
                    state_d      = ST_SCAN;
                    settle_cnt_d = '0;
                end else begin
                    settle_cnt_d = settle_cnt_q + 4'd1;
                end
            end
            ST_SCAN: begin
                if (drain_q) begin
                    // Last square fully sampled; finish once its final move is taken.
                    if (!move_valid_q) begin
                        state_d  = ST_DONE;
                        sq_sel_d = '0;
                        drain_d  = 1'b0;
                    end
                end else if (!move_valid_q) begin
                    if (!dir_empty) begin
                        move_valid_d = 1'b1;
                        move_data_d  = dir_word;
                        move_count_d = sat_inc(move_count_q);
                    end
                    dir_idx_d = dir_idx_q + 4'd1;
                    if (dir_idx_q == LAST_DIR) begin
                        if (sq_sel_q != LAST_SQ) begin
                            sq_sel_d     = sq_sel_q + 6'd1;
                            settle_cnt_d = '0;
                            state_d      = ST_SETTLE;
                        end else if (dir_empty) begin
                            state_d  = ST_DONE;
                            sq_sel_d = '0;
                        end else begin
                            drain_d = 1'b1;
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort && (state_q != ST_IDLE)) begin
            state_d      = ST_IDLE;
            sq_sel_d     = '0;
            dir_idx_d    = '0;
            settle_cnt_d = '0;
            move_valid_d = 1'b0;
            drain_d      = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            sq_sel_q     <= '0;
            dir_idx_q    <= '0;
            settle_cnt_q <= '0;
            move_valid_q <= 1'b0;
            move_data_q  <= '0;
            move_count_q <= '0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            drain_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            sq_sel_q     <= sq_sel_d;
            dir_idx_q    <= dir_idx_d;
            settle_cnt_q <= settle_cnt_d;
            move_valid_q <= move_valid_d;
            move_data_q  <= move_data_d;
            move_count_q <= move_count_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
            drain_q      <= drain_d;
        end
    end

    assign sq_sel     = sq_sel_q;
    assign busy       = busy_q;
    assign move_valid = move_valid_q;
    assign move_data  = move_data_q;
    assign move_count = move_count_q;
    assign done       = done_q;

endmodule

// File: tb/tb_move_scan_scheduler.sv
// Directed bench for move_scan_scheduler: table of single-scan scenarios plus
// hand sequences for abort, busy start and asynchronous reset.
module tb_move_scan_scheduler;

    logic          clk;
    logic          reset;
    logic          start;
    logic          abort;
    logic [383:0]  moves_in;
    logic [5:0]    sq_sel;
    logic          busy;
    logic          move_valid;
    logic [23:0]   move_data;
    logic          move_ready;
    logic [10:0]   move_count;
    logic          done;

    logic [383:0]  board [64];
    int            n_checks;
    int            n_errors;

    typedef struct {
        int          sq;
        int          dir_a;
        logic [23:0] word_a;
        int          dir_b;
        logic [23:0] word_b;
        int          rdy_delay;
        int          exp_lat;
        int          exp_count;
    } vec_t;

    vec_t vecs [6];
    int   lats [6];

    move_scan_scheduler #(.SETTLE_CYCLES(4), .NUM_SQUARES(64)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .moves_in   (moves_in),
        .sq_sel     (sq_sel),
        .busy       (busy),
        .move_valid (move_valid),
        .move_data  (move_data),
        .move_ready (move_ready),
        .move_count (move_count),
        .done       (done)
    );

    // Stand-in for the square array and its external 64:1 mux.
    assign moves_in = board[sq_sel];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_board();
        for (int i = 0; i < 64; i++) board[i] = '0;
    endtask

    task automatic wait_sq(input logic [5:0] sq, input int limit, output bit ok);
        int k;
        k = 0;
        while (sq_sel != sq && k < limit) begin
            tick();
            k++;
        end
        ok = (sq_sel == sq);
    endtask

    task automatic run_vec(input vec_t v, output int lat);
        int          k;
        int          hold;
        int          last_valid_k;
        bit          delay_used;
        logic [23:0] tx [$];
        int          tx_sq [$];

        clear_board();
        board[6'(v.sq)][v.dir_a*24 +: 24] = v.word_a;
        if (v.word_b != 24'h0) board[6'(v.sq)][v.dir_b*24 +: 24] = v.word_b;
        move_ready   = 1'b1;
        delay_used   = 1'b0;
        hold         = 0;
        last_valid_k = 0;

        start = 1'b1;
        tick();
        start = 1'b0;
        k = 0;
        check("busy_after_start", 32'(busy), 32'd1);

        while (!done && k < 2000) begin
            if (move_valid) begin
                last_valid_k = k;
                if (!delay_used && v.rdy_delay > 0) begin
                    delay_used = 1'b1;
                    move_ready = 1'b0;
                    hold       = v.rdy_delay;
                end else if (!move_ready) begin
                    check("stall_data", 32'(move_data), 32'(v.word_a));
                    check("stall_sq", 32'(sq_sel), 32'(v.sq));
                    hold--;
                    if (hold == 0) move_ready = 1'b1;
                end
                if (move_ready) begin
                    tx.push_back(move_data);
                    tx_sq.push_back(int'(sq_sel));
                end
            end
            tick();
            k++;
        end
        lat = k;
        move_ready = 1'b1;

        check("done_seen", 32'(done), 32'd1);
        if (v.exp_lat >= 0) check("latency", 32'(lat), 32'(v.exp_lat));
        check("move_count", 32'(move_count), 32'(v.exp_count));
        check("transfers", 32'(tx.size()), 32'(v.exp_count));
        if (tx.size() >= 1) begin
            check("tx0_data", 32'(tx[0]), 32'(v.word_a));
            check("tx0_sq", 32'(tx_sq[0]), 32'(v.sq));
        end
        if (tx.size() >= 2) check("tx1_data", 32'(tx[1]), 32'(v.word_b));
        if (v.sq == 63 && v.dir_a == 15 && v.word_a != 24'h0)
            check("done_after_drop", 32'(lat), 32'(last_valid_k + 2));
        check("sq_at_done", 32'(sq_sel), 32'd0);

        tick();
        check("done_pulse_1cyc", 32'(done), 32'd0);
        check("idle_after_done", 32'(busy), 32'd0);
        check("count_holds", 32'(move_count), 32'(v.exp_count));
    endtask

    initial begin
        bit ok;
        int done_hits;

        n_checks   = 0;
        n_errors   = 0;
        reset      = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        move_ready = 1'b1;
        clear_board();

        //               sq  dirA wordA        dirB wordB        dly  lat   cnt
        vecs[0] = '{sq:  0, dir_a: 0, word_a: 24'h000000, dir_b: 0, word_b: 24'h000000, rdy_delay: 0,  exp_lat: 1280, exp_count: 0};
        vecs[1] = '{sq:  5, dir_a: 2, word_a: 24'h051A0C, dir_b:15, word_b: 24'h050206, rdy_delay: 0,  exp_lat: -1,   exp_count: 2};
        vecs[2] = '{sq:  5, dir_a: 2, word_a: 24'h051A0C, dir_b:15, word_b: 24'h050206, rdy_delay: 10, exp_lat: -1,   exp_count: 2};
        vecs[3] = '{sq: 63, dir_a:15, word_a: 24'h3F0102, dir_b: 0, word_b: 24'h000000, rdy_delay: 3,  exp_lat: 1285, exp_count: 1};
        vecs[4] = '{sq:  0, dir_a: 0, word_a: 24'h000001, dir_b: 0, word_b: 24'h000000, rdy_delay: 0,  exp_lat: 1281, exp_count: 1};
        vecs[5] = '{sq: 12, dir_a: 7, word_a: 24'h00FFFF, dir_b: 8, word_b: 24'h123456, rdy_delay: 2,  exp_lat: 1284, exp_count: 2};

        tick();
        tick();
        check("rst_sq_sel", 32'(sq_sel), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(move_valid), 32'd0);
        check("rst_data", 32'(move_data), 32'd0);
        check("rst_count", 32'(move_count), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) run_vec(vecs[i], lats[i]);
        check("ready_stall_delay", 32'(lats[2]), 32'(lats[1] + 10));

        // Abort while a move is pending on square 20.
        clear_board();
        board[20][3*24 +: 24] = 24'h140305;
        move_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 1000 && !(move_valid && sq_sel == 6'd20); k++) tick();
        check("abort_reach_valid", 32'(move_valid && sq_sel == 6'd20), 32'd1);
        check("abort_pre_count", 32'(move_count), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(move_valid), 32'd0);
        check("abort_count_holds", 32'(move_count), 32'd1);
        done_hits = int'(done);
        for (int k = 0; k < 5; k++) begin
            tick();
            done_hits += int'(done);
        end
        check("abort_no_done", 32'(done_hits), 32'd0);

        // Start together with abort in IDLE: start wins.
        move_ready = 1'b1;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("restart_busy", 32'(busy), 32'd1);
        check("restart_sq", 32'(sq_sel), 32'd0);
        check("restart_count", 32'(move_count), 32'd0);

        // A start pulse while busy must not restart the scan.
        wait_sq(6'd3, 200, ok);
        check("reach_sq3", 32'(ok), 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_start_ignored", 32'(sq_sel), 32'd3);
        check("busy_start_busy", 32'(busy), 32'd1);

        // Asynchronous reset between clock edges at square 40.
        wait_sq(6'd40, 2000, ok);
        check("reach_sq40", 32'(ok), 32'd1);
        check("pre_reset_count", 32'(move_count), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_sq_sel", 32'(sq_sel), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_valid", 32'(move_valid), 32'd0);
        check("arst_data", 32'(move_data), 32'd0);
        check("arst_count", 32'(move_count), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        tick();
        check("arst_stays_idle", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
